// File: rtl/uart_rx_deserializer_if.sv
// Receive-side handshake bundle: head-of-FIFO data with its error flags,
// plus the consumer's ready.
`timescale 1ns/1ps
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_err;
    logic                  frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes rx, samples each bit at mid-bit, and queues
// {data, parity_err, frame_err} in a small FIFO with overrun detection.
`timescale 1ns/1ps
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    uart_rx_deserializer_if.master rx_bus,
    output logic                   overrun_err,
    output logic                   busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic rx_meta_reg;
    logic rx_sync_reg;
    logic rx_prev_reg;

    state_t                state_reg, state_next;
    logic [CW-1:0]         clk_cnt_reg, clk_cnt_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  par_err_reg, par_err_next;
    logic                  push;
    logic                  push_frame_err;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          overrun_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic [EW-1:0] head;

    // rx_prev tracks the synchronized line so IDLE only reacts to a real falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_err_reg <= par_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        clk_cnt_next   = clk_cnt_reg + 1'b1;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        par_err_next   = par_err_reg;
        push           = 1'b0;
        push_frame_err = 1'b0;
        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                par_err_next = 1'b0;
                if (rx_prev_reg && !rx_sync_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = rx_sync_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {rx_sync_reg, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    par_err_next = (^shift_reg) ^ rx_sync_reg ^ 1'(PARITY_ODD);
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next   = '0;
                    push           = 1'b1;
                    push_frame_err = !rx_sync_reg;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
            end
        endcase
    end

    // Extra pointer MSB tells full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop        = !fifo_empty && rx_bus.rx_ready;
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            overrun_reg <= push && !push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= {shift_reg, par_err_reg, push_frame_err};
        end
    end

    // Gate the head with empty so outputs read zero after reset regardless of RAM contents.
    assign head                = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign rx_bus.rx_data      = head[EW-1:2];
    assign rx_bus.parity_err   = head[1];
    assign rx_bus.frame_err    = head[0];
    assign rx_bus.rx_valid     = !fifo_empty;
    assign overrun_err         = overrun_reg;
    assign busy                = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: stimulus tasks queue expected entries, a negedge monitor
// pops and compares each accepted FIFO head.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic overrun_err;
    logic busy;

    int total   = 0;
    int bad     = 0;
    int ovr_cnt = 0;

    logic [9:0] exp_q [$];

    uart_rx_deserializer_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (8),
        .PARITY_EN   (1),
        .PARITY_ODD  (0),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_bus     (bus),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted head entry is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus.rx_valid && bus.rx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_entry got data=%h pe=%b fe=%b required=none",
                         bus.rx_data, bus.parity_err, bus.frame_err);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({bus.rx_data, bus.parity_err, bus.frame_err} !== e) begin
                    bad++;
                    $display("FAIL entry got data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                             bus.rx_data, bus.parity_err, bus.frame_err, e[9:2], e[1], e[0]);
                end else begin
                    $display("rx entry data=%h pe=%b fe=%b ok", bus.rx_data, bus.parity_err,
                             bus.frame_err);
                end
            end
        end
        if (overrun_err) ovr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic expect_entry(input logic [7:0] d, input logic pe, input logic fe);
        exp_q.push_back({d, pe, fe});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // {data, parity bit on the wire, stop bit, expected pe, expected fe}
    logic [11:0] vec [6];

    initial begin
        vec[0] = {8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[1] = {8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[2] = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[3] = {8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[4] = {8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[5] = {8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};

        bus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_valid", bus.rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_data", bus.rx_data, 0);
        check("reset_flags", {bus.parity_err, bus.frame_err, overrun_err}, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            expect_entry(vec[v][11:4], vec[v][1], vec[v][0]);
            send_frame(vec[v][11:4], vec[v][3], vec[v][2]);
            rx = 1'b1;
            wait_drain("frame_drain");
        end

        // Break: bad stop bit, then line held low; exactly one entry expected.
        expect_entry(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        check("break_busy_idle", busy, 0);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        wait_drain("break_drain");

        // Glitch: 4 clocks low must not produce a frame.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_high", busy, 1);
        begin
            int k;
            k = 0;
            while (busy && k < 8) begin
                @(negedge clk);
                k++;
            end
            check("glitch_busy_low", busy, 0);
        end
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_valid", bus.rx_valid, 0);

        // Overrun: five frames into a depth-4 FIFO with no consumer.
        bus.rx_ready = 1'b0;
        ovr_cnt = 0;
        expect_entry(8'h01, 1'b0, 1'b0);
        expect_entry(8'h02, 1'b0, 1'b0);
        expect_entry(8'h03, 1'b0, 1'b0);
        expect_entry(8'h04, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, 1'b1);
        send_frame(8'h03, 1'b0, 1'b1);
        send_frame(8'h04, 1'b1, 1'b1);
        send_frame(8'h05, 1'b0, 1'b1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("overrun_pulses", ovr_cnt, 1);
        check("full_valid", bus.rx_valid, 1);
        bus.rx_ready = 1'b1;
        wait_drain("overrun_drain");
        repeat (4) @(negedge clk);
        check("empty_after_drain", bus.rx_valid, 0);

        // Reset during bit 3 of 0x55; only the following 0x0F may arrive.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("midframe_busy", busy, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_valid", bus.rx_valid, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("post_reset_valid", bus.rx_valid, 0);
        expect_entry(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1);
        rx = 1'b1;
        wait_drain("post_reset_drain");
        repeat (2 * CPB) @(negedge clk);
        check("final_overruns", ovr_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; even, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY_EN, default 1: 1 = one parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries; power of 2.
REQ-006 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port rx, input, 1: asynchronous serial line; idle high.
REQ-009 SHALL have port rx_data, output, DATA_WIDTH: data of the FIFO head entry.
REQ-010 SHALL have port rx_valid, output, 1: FIFO not empty.
REQ-011 SHALL have port rx_ready, input, 1: consumer accepts the head entry.
REQ-012 SHALL have port parity_err, output, 1: parity-error flag of the head entry.
REQ-013 SHALL have port frame_err, output, 1: stop-bit-error flag of the head entry.
REQ-014 SHALL have port overrun_err, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all further rx references mean the synchronized value.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with one bit counter and one clock counter (0..CLKS_PER_BIT-1).
REQ-018 IDLE: on a 1->0 transition of rx, SHALL go to START and clear the clock counter; a line held low SHALL NOT retrigger.
REQ-019 START: at clock count CLKS_PER_BIT/2-1, SHALL go to DATA if rx=0; if rx=1 (glitch) SHALL return to IDLE with no output.
REQ-020 DATA: SHALL sample rx every CLKS_PER_BIT clocks (mid-bit) and shift it in LSB first; after DATA_WIDTH samples, SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-021 PARITY: SHALL sample at mid-bit; parity_err = (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0; SHALL then go to STOP.
REQ-022 STOP: SHALL sample at mid-bit; frame_err = (sample==0); SHALL push {data, parity_err, frame_err} and go to IDLE on the same edge, so a start bit arriving immediately after is detected.
REQ-023 When PARITY_EN=0, the stored parity_err SHALL be 0.
REQ-024 A frame with frame_err=1 SHALL still be pushed; because IDLE needs a 1->0 edge, a break condition (line held low) SHALL produce exactly one frame.
REQ-025 FIFO: rx_valid = not empty; rx_data, parity_err and frame_err SHALL show the head entry; a pop SHALL occur on a clk edge where rx_valid and rx_ready are both 1.
REQ-026 rx_valid SHALL rise on the clock cycle after the stop-bit sample edge when the FIFO was empty.
REQ-027 A push while the FIFO is full with no pop in the same cycle SHALL drop the new frame and pulse overrun_err for 1 cycle; stored entries SHALL be unchanged.
REQ-028 A simultaneous push and pop while full SHALL accept the push with no overrun; a simultaneous push and pop while empty SHALL behave as a normal push.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-030 Outputs SHALL be registered or derived only from state, never combinationally from rx.

Reset
REQ-031 On rst=0, asynchronously: FSM=IDLE, counters=0, FIFO empty, rx_valid=0, rx_data=0, parity_err=0, frame_err=0, overrun_err=0, busy=0, synchronizer=1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a new 1->0 edge.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8, even parity, FIFO_DEPTH=4)
REQ-033 Send 0xA5 with parity 0 and stop 1, rx_ready=1 -> one rx_valid with rx_data=0xA5, parity_err=0, frame_err=0.
REQ-034 Send 0xA5 with parity 1 -> rx_data=0xA5, parity_err=1.
REQ-035 Send 0x3C with stop bit 0, then hold rx low for 40 bit times -> exactly one entry, frame_err=1.
REQ-036 rx low for 4 clocks, then high -> no rx_valid; busy returns to 0 within 8 clocks.
REQ-037 rx_ready=0, send 0x01..0x05 back to back -> overrun_err pulses once (frame 0x05); then set rx_ready=1 -> pops 0x01, 0x02, 0x03, 0x04 in order.
REQ-038 Assert rst during bit 3 of 0x55, release, send 0x0F -> only 0x0F is received.
